// File: rtl/bflsh_pkg.sv
// Shared state encoding and sizing helpers for the bound flasher.
package bflsh_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    UP_LO  = 3'd1,
    DN_0A  = 3'd2,
    UP_MID = 3'd3,
    DN_LO  = 3'd4,
    UP_MAX = 3'd5,
    DN_0B  = 3'd6
  } state_t;

  // cnt must reach MX_LP itself (all lamps on), hence MX_LP+1 codes.
  function automatic int cnt_width(input int mx_lp);
    return $clog2(mx_lp + 1);
  endfunction

endpackage

// File: rtl/bflsh_therm.sv
// Lamp count to thermometer vector: lamp[i] is lit when i < cnt.
module bflsh_therm
  import bflsh_pkg::*;
#(
  parameter int MX_LP = 16,
  parameter int CW    = cnt_width(MX_LP)
) (
  input  logic [CW-1:0]    cnt,
  output logic [MX_LP-1:0] lamp
);

  for (genvar i = 0; i < MX_LP; i++) begin : g_lamp
    assign lamp[i] = (cnt > CW'(i));
  end

endmodule

// File: rtl/bound_flasher_param.sv
// Bound flasher: lamp bar ramps between parameterised bounds, with optional
// kickback on flick at selected bounds.
//
//   state  | meaning
//   IDLE   | waiting for flick, all lamps off
//   UP_LO  | rising to BND_LO+1
//   DN_0A  | falling to 0, then UP_MID
//   UP_MID | rising to BND_MID+1 (kickback to DN_0A possible)
//   DN_LO  | falling to BND_LO
//   UP_MAX | rising to MX_LP (kickback to DN_LO possible)
//   DN_0B  | falling to 0, then IDLE with a_done pulse
module bound_flasher_param
  import bflsh_pkg::*;
#(
  parameter int MX_LP   = 16,
  parameter int BND_LO  = 5,
  parameter int BND_MID = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flick,
  input  logic               kick_en,
  output logic [MX_LP-1:0]   a_lamp,
  output logic [STATE_W-1:0] a_next_state,
  output logic               a_done
);

  localparam int CW = cnt_width(MX_LP);
  localparam logic [CW-1:0] CNT_LO   = CW'(BND_LO);
  localparam logic [CW-1:0] CNT_LO1  = CW'(BND_LO + 1);
  localparam logic [CW-1:0] CNT_MID1 = CW'(BND_MID + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MX_LP);

  if (MX_LP < 4 || MX_LP > 64 || BND_LO <= 0 || BND_LO >= BND_MID
      || BND_MID >= MX_LP - 1) begin : g_bad_params
    $error("bound_flasher_param: illegal MX_LP/BND_LO/BND_MID combination");
  end

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [MX_LP-1:0]  lamp_nxt;
  logic              done_nxt;
  logic              kick;

  assign kick = kick_en & flick;

  // Transitions are decided on the value cnt takes at this edge (cnt_nxt).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (flick) state_nxt = UP_LO;
      end
      UP_LO: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt == CNT_LO1) state_nxt = DN_0A;
      end
      DN_0A: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) state_nxt = UP_MID;
      end
      UP_MID: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt == CNT_MID1)                state_nxt = kick ? DN_0A : DN_LO;
        else if (kick && cnt_nxt == CNT_LO1)    state_nxt = DN_0A;
      end
      DN_LO: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == CNT_LO) state_nxt = UP_MAX;
      end
      UP_MAX: begin
        cnt_nxt = cnt + 1'b1;
        if (kick && cnt_nxt == CNT_MID1) state_nxt = DN_LO;
        else if (cnt_nxt == CNT_MAX)     state_nxt = DN_0B;
      end
      DN_0B: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign a_next_state = rst_n ? state_nxt : IDLE;

  bflsh_therm #(.MX_LP(MX_LP), .CW(CW)) u_therm (
    .cnt  (cnt_nxt),
    .lamp (lamp_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_lamp <= '0;
      a_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      a_lamp <= lamp_nxt;
      a_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bound_flasher_param.sv
// Bench for bound_flasher_param: default and small configurations side by side,
// checked every cycle against a segment-table model plus literal expectations.
module tb_bound_flasher_param;

  localparam int MX  = 16, LO  = 5, MID  = 10;
  localparam int MXS = 8,  LOS = 2, MIDS = 5;

  logic clk = 1'b0, rst_n = 1'b0, flick = 1'b0, kick_en = 1'b0;
  logic [MX-1:0]  lamp_b;
  logic [MXS-1:0] lamp_s;
  logic [2:0]     ns_b, ns_s;
  logic           done_b, done_s;

  always #5 clk = ~clk;

  bound_flasher_param dut_b (
    .clk(clk), .rst_n(rst_n), .flick(flick), .kick_en(kick_en),
    .a_lamp(lamp_b), .a_next_state(ns_b), .a_done(done_b)
  );

  bound_flasher_param #(.MX_LP(MXS), .BND_LO(LOS), .BND_MID(MIDS)) dut_s (
    .clk(clk), .rst_n(rst_n), .flick(flick), .kick_en(kick_en),
    .a_lamp(lamp_s), .a_next_state(ns_s), .a_done(done_s)
  );

  int n_checks = 0, n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] therm(input int c);
    return (64'd1 << c) - 64'd1;
  endfunction

  // A sequence is six ramps, each heading for a target lamp count; seg -1 is idle.
  // Segment k corresponds to state code k+1; even segments rise.
  function automatic void step(input int mx, input int lo, input int mid,
                               input int seg, input int c, input logic fl, input logic ke,
                               output int nseg, output int nc, output logic nd);
    int tgt [6];
    tgt = '{lo + 1, 0, mid + 1, lo, mx, 0};
    nseg = seg; nc = c; nd = 1'b0;
    if (seg < 0) begin
      if (fl) nseg = 0;
    end else begin
      nc = c + ((seg % 2 == 0) ? 1 : -1);
      if (fl && ke && seg == 2 && (nc == lo + 1 || nc == mid + 1)) nseg = 1;
      else if (fl && ke && seg == 4 && nc == mid + 1)             nseg = 3;
      else if (nc == tgt[seg]) begin
        nseg = seg + 1;
        if (nseg == 6) begin
          nseg = -1;
          nd   = 1'b1;
        end
      end
    end
  endfunction

  int   mb_seg = -1, mb_cnt = 0, ms_seg = -1, ms_cnt = 0;
  logic mb_done = 1'b0, ms_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int s, c;
    logic d;
    if (!rst_n) begin
      mb_seg <= -1; mb_cnt <= 0; mb_done <= 1'b0;
      ms_seg <= -1; ms_cnt <= 0; ms_done <= 1'b0;
    end else begin
      step(MX, LO, MID, mb_seg, mb_cnt, flick, kick_en, s, c, d);
      mb_seg <= s; mb_cnt <= c; mb_done <= d;
      step(MXS, LOS, MIDS, ms_seg, ms_cnt, flick, kick_en, s, c, d);
      ms_seg <= s; ms_cnt <= c; ms_done <= d;
    end
  end

  always @(negedge clk) begin
    int s, c;
    logic d;
    if (!rst_n) begin
      chk("next_b_rst", ns_b, 0);
      chk("lamp_b_rst", lamp_b, 0);
      chk("next_s_rst", ns_s, 0);
      chk("lamp_s_rst", lamp_s, 0);
    end else begin
      step(MX, LO, MID, mb_seg, mb_cnt, flick, kick_en, s, c, d);
      chk("next_b", ns_b, s + 1);
      chk("lamp_b", lamp_b, therm(mb_cnt));
      chk("done_b", done_b, mb_done);
      step(MXS, LOS, MIDS, ms_seg, ms_cnt, flick, kick_en, s, c, d);
      chk("next_s", ns_s, s + 1);
      chk("lamp_s", lamp_s, therm(ms_cnt));
      chk("done_s", done_s, ms_done);
    end
  end

  task automatic wait_big(input int seg, input int c, input string tag);
    int k = 0;
    while (!(mb_seg == seg && mb_cnt == c) && k < 300) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting for seg %0d cnt %0d", tag, seg, c);
    end
  endtask

  task automatic pulse_start();
    flick = 1'b1;
    @(posedge clk); #2;
    flick = 1'b0;
  endtask

  function automatic void extrema(input int v[$], output int e[$]);
    e = {};
    for (int i = 1; i + 1 < v.size(); i++) begin
      int d0, d1;
      d0 = v[i] - v[i-1];
      d1 = v[i+1] - v[i];
      if (d0 != 0 && d1 != 0 && ((d0 > 0) != (d1 > 0))) e.push_back(v[i]);
    end
    if (v.size() > 0) e.push_back(v[v.size()-1]);
  endfunction

  task automatic chk_extrema(input string tag, input int v[$], input int exp[6]);
    int e[$];
    extrema(v, e);
    chk({tag, "_count"}, e.size(), 6);
    for (int i = 0; i < 6; i++)
      chk(tag, (i < e.size()) ? e[i] : -1, exp[i]);
  endtask

  initial begin
    int traj_b[$], traj_s[$];
    int k, edge_b, edge_s;
    int exp_b[6], exp_s[6];
    exp_b = '{6, 0, 11, 5, 16, 0};
    exp_s = '{3, 0, 6, 2, 8, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lamp", lamp_b, 0);
    chk("rst_next", ns_b, 0);
    chk("rst_done", done_b, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;

    // Full sequence without kickback on both configurations
    kick_en = 1'b0;
    flick = 1'b1;
    #1 chk("start_next", ns_b, 1);
    @(posedge clk); #2;
    flick = 1'b0;
    @(negedge clk);
    traj_b.push_back($countones(lamp_b));
    traj_s.push_back($countones(lamp_s));
    k = 0; edge_b = -1; edge_s = -1;
    while (k < 80 && edge_b < 0) begin
      @(posedge clk); k++;
      @(negedge clk);
      traj_b.push_back($countones(lamp_b));
      if (edge_s < 0) traj_s.push_back($countones(lamp_s));
      if (done_b) edge_b = k;
      if (done_s && edge_s < 0) edge_s = k;
    end
    chk("done_edges_b", edge_b, 56);
    chk("done_edges_s", edge_s, 30);
    chk_extrema("peaks_b", traj_b, exp_b);
    chk_extrema("peaks_s", traj_s, exp_s);
    @(posedge clk); #2;
    chk("done_one_cycle", done_b, 0);

    // Kickback enabled: non-bound flicks ignored, bound flick in UP_MID
    kick_en = 1'b1;
    pulse_start();
    wait_big(2, 2, "wait_mid2");
    flick = 1'b1;
    #1 chk("nonbound3_next", ns_b, 3);
    @(posedge clk); #2; flick = 1'b0;
    wait_big(2, 7, "wait_mid7");
    flick = 1'b1;
    #1 chk("nonbound8_next", ns_b, 3);
    @(posedge clk); #2; flick = 1'b0;
    wait_big(2, 10, "wait_mid10");
    flick = 1'b1;
    #1 chk("kick_mid_next", ns_b, 2);
    @(posedge clk); #2; flick = 1'b0;
    chk("kick_mid_lamps", $countones(lamp_b), 11);
    repeat (11) @(posedge clk);
    #2;
    chk("kick_mid_bottom", $countones(lamp_b), 0);
    chk("kick_mid_resume", ns_b, 3);

    // Kickback in UP_MAX back to DN_LO
    wait_big(4, 10, "wait_max10");
    flick = 1'b1;
    #1 chk("kick_max_next", ns_b, 4);
    @(posedge clk); #2; flick = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("kick_max_bottom", $countones(lamp_b), 5);
    chk("kick_max_resume", ns_b, 5);
    wait_big(-1, 0, "wait_idle1");

    // Same flick with kickback disabled, held across later bounds
    kick_en = 1'b0;
    pulse_start();
    wait_big(2, 10, "wait_mid10_nokick");
    flick = 1'b1;
    #1 chk("nokick_mid_next", ns_b, 4);
    repeat (20) @(posedge clk);
    #2; flick = 1'b0;
    wait_big(-1, 0, "wait_idle2");

    // Asynchronous reset mid-sequence, then restart
    pulse_start();
    wait_big(4, 9, "wait_max9");
    #1 rst_n = 1'b0;
    #1;
    chk("async_lamp", lamp_b, 0);
    chk("async_next", ns_b, 0);
    chk("async_done", done_b, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    flick = 1'b1;
    #1 chk("restart_next", ns_b, 1);
    @(posedge clk); #2; flick = 1'b0;
    chk("restart_lamps", $countones(lamp_b), 0);
    chk("restart_state", ns_b, 1);
    repeat (8) @(posedge clk);
    #2;
    chk("restart_peak_path", $countones(lamp_b), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
